// File: rtl/sys_arr_row_db.sv
// One row of the systolic matrix-multiply array: activations ripple right, partial sums flow down,
// weights are preloaded into shadow registers over a serial chain and swapped in atomically.
module sys_arr_row_db #(
  parameter int ROW_WIDTH = 4,
  parameter int DATA_W    = 8,
  parameter int SUM_W     = 16,
  parameter int SAT       = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           active,
  input  logic [DATA_W-1:0]              datain,
  input  logic [ROW_WIDTH*SUM_W-1:0]     sumin,
  input  logic                           wload,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           wswap,
  output logic [ROW_WIDTH*SUM_W-1:0]     maccout,
  output logic [ROW_WIDTH-1:0]           activeout,
  output logic [ROW_WIDTH-1:0]           satout,
  output logic [DATA_W-1:0]              dataout,
  output logic                           wready,
  output logic [$clog2(ROW_WIDTH+1)-1:0] wcount
);

  localparam int CW = $clog2(ROW_WIDTH + 1);
  localparam logic [CW-1:0]    FULL = CW'(ROW_WIDTH);
  localparam logic [SUM_W-1:0] SMAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SMIN = {1'b1, {(SUM_W-1){1'b0}}};

  logic signed [DATA_W-1:0] r_data [ROW_WIDTH];
  logic signed [DATA_W-1:0] r_wsh  [ROW_WIDTH];
  logic signed [DATA_W-1:0] r_wact [ROW_WIDTH];
  logic [SUM_W-1:0]         r_macc [ROW_WIDTH];
  logic [ROW_WIDTH-1:0]     r_act;
  logic [ROW_WIDTH-1:0]     r_sat;
  logic [CW-1:0]            r_wcount;

  logic signed [DATA_W-1:0]   w_inData [ROW_WIDTH];
  logic signed [2*DATA_W-1:0] w_prod   [ROW_WIDTH];
  logic [SUM_W:0]             w_sum    [ROW_WIDTH];
  logic [SUM_W-1:0]           w_next   [ROW_WIDTH];
  logic [ROW_WIDTH-1:0]       w_inAct;
  logic [ROW_WIDTH-1:0]       w_ovf;
  logic                       w_swapOk;

  assign w_swapOk = wswap && (r_wcount == FULL);

  // One extra sum bit makes overflow visible as a mismatch of the top two bits.
  always_comb begin
    w_inAct     = '0;
    w_ovf       = '0;
    w_inData[0] = datain;
    w_inAct[0]  = active;
    for (int i = 1; i < ROW_WIDTH; i++) begin
      w_inData[i] = r_data[i-1];
      w_inAct[i]  = r_act[i-1];
    end
    for (int i = 0; i < ROW_WIDTH; i++) begin
      w_prod[i] = (2*DATA_W)'(w_inData[i]) * (2*DATA_W)'(r_wact[i]);
      w_sum[i]  = {{(SUM_W+1-2*DATA_W){w_prod[i][2*DATA_W-1]}}, w_prod[i]}
                + {sumin[i*SUM_W+SUM_W-1], sumin[i*SUM_W +: SUM_W]};
      w_ovf[i]  = w_sum[i][SUM_W] ^ w_sum[i][SUM_W-1];
      w_next[i] = w_sum[i][SUM_W-1:0];
      if ((SAT != 0) && w_ovf[i]) begin
        w_next[i] = w_sum[i][SUM_W] ? SMIN : SMAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROW_WIDTH; i++) begin
        r_data[i] <= '0;
        r_wsh[i]  <= '0;
        r_wact[i] <= '0;
        r_macc[i] <= '0;
      end
      r_act    <= '0;
      r_sat    <= '0;
      r_wcount <= '0;
    end else begin
      for (int i = 0; i < ROW_WIDTH; i++) begin
        r_data[i] <= w_inData[i];
        r_act[i]  <= w_inAct[i];
        if (w_inAct[i]) begin
          r_macc[i] <= w_next[i];
          r_sat[i]  <= w_ovf[i];
        end
        if (w_swapOk) begin
          r_wact[i] <= r_wsh[i];
        end
      end
      // A swap on the same edge as a load captures the pre-shift shadows.
      if (wload) begin
        r_wsh[0] <= wdata;
        for (int i = 1; i < ROW_WIDTH; i++) begin
          r_wsh[i] <= r_wsh[i-1];
        end
      end
      if (w_swapOk) begin
        r_wcount <= wload ? CW'(1) : '0;
      end else if (wload && (r_wcount != FULL)) begin
        r_wcount <= r_wcount + CW'(1);
      end
    end
  end

  always_comb begin
    maccout = '0;
    for (int i = 0; i < ROW_WIDTH; i++) begin
      maccout[i*SUM_W +: SUM_W] = r_macc[i];
    end
  end

  assign activeout = r_act;
  assign satout    = r_sat;
  assign dataout   = r_data[ROW_WIDTH-1];
  assign wready    = (r_wcount == FULL);
  assign wcount    = r_wcount;

endmodule

// File: tb/tb_sys_arr_row_db.sv
// Bench for sys_arr_row_db: three configurations (4x8x16 wrap, 4x8x16 saturating, 8x4x12 wrap)
// driven from one stimulus stream and checked every cycle against an integer model of the row.
module tb_sys_arr_row_db;

  logic clk = 1'b0;
  logic rst_n, active, wload, wswap;
  logic [7:0]  datainA, wdataA;
  logic [3:0]  datainC, wdataC;
  logic [63:0] suminA;
  logic [95:0] suminC;

  logic [63:0] maccA, maccB;
  logic [95:0] maccC;
  logic [3:0]  actA, actB, satA, satB;
  logic [7:0]  actC, satC;
  logic [7:0]  dataA, dataB;
  logic [3:0]  dataC;
  logic        wrA, wrB, wrC;
  logic [2:0]  wcA, wcB;
  logic [3:0]  wcC;

  int nTests = 0;
  int nFail  = 0;

  // stimulus for the current cycle, shared by all instances (truncated per width)
  int sDat, sWdat;
  int sSum [8];
  bit sAct, sWload, sWswap;

  // model state per instance
  int mDat  [3][8];
  int mWsh  [3][8];
  int mWact [3][8];
  int mMacc [3][8];
  bit mAct  [3][8];
  bit mSat  [3][8];
  int mCnt  [3];

  always #5 clk = ~clk;

  sys_arr_row_db #(.ROW_WIDTH(4), .DATA_W(8), .SUM_W(16), .SAT(0)) dutA (
    .clk(clk), .rst_n(rst_n), .active(active), .datain(datainA), .sumin(suminA),
    .wload(wload), .wdata(wdataA), .wswap(wswap), .maccout(maccA), .activeout(actA),
    .satout(satA), .dataout(dataA), .wready(wrA), .wcount(wcA));

  sys_arr_row_db #(.ROW_WIDTH(4), .DATA_W(8), .SUM_W(16), .SAT(1)) dutB (
    .clk(clk), .rst_n(rst_n), .active(active), .datain(datainA), .sumin(suminA),
    .wload(wload), .wdata(wdataA), .wswap(wswap), .maccout(maccB), .activeout(actB),
    .satout(satB), .dataout(dataB), .wready(wrB), .wcount(wcB));

  sys_arr_row_db #(.ROW_WIDTH(8), .DATA_W(4), .SUM_W(12), .SAT(0)) dutC (
    .clk(clk), .rst_n(rst_n), .active(active), .datain(datainC), .sumin(suminC),
    .wload(wload), .wdata(wdataC), .wswap(wswap), .maccout(maccC), .activeout(actC),
    .satout(satC), .dataout(dataC), .wready(wrC), .wcount(wcC));

  function automatic int cRow(int n); return (n == 2) ? 8 : 4; endfunction
  function automatic int cDw(int n);  return (n == 2) ? 4 : 8; endfunction
  function automatic int cSw(int n);  return (n == 2) ? 12 : 16; endfunction
  function automatic bit cSat(int n); return (n == 1); endfunction

  // two's-complement value of the low w bits of v
  function automatic int wrapTo(int v, int w);
    int m;
    m = v & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m = m - (1 << w);
    return m;
  endfunction

  function automatic int getMacc(int n, int i);
    case (n)
      0:       return wrapTo(int'(maccA >> (i * 16)), 16);
      1:       return wrapTo(int'(maccB >> (i * 16)), 16);
      default: return wrapTo(int'(maccC >> (i * 12)), 12);
    endcase
  endfunction

  function automatic int getAct(int n);
    case (n)
      0: return int'(actA); 1: return int'(actB); default: return int'(actC);
    endcase
  endfunction

  function automatic int getSat(int n);
    case (n)
      0: return int'(satA); 1: return int'(satB); default: return int'(satC);
    endcase
  endfunction

  function automatic int getData(int n);
    case (n)
      0: return wrapTo(int'(dataA), 8); 1: return wrapTo(int'(dataB), 8);
      default: return wrapTo(int'(dataC), 4);
    endcase
  endfunction

  function automatic int getWr(int n);
    case (n)
      0: return int'(wrA); 1: return int'(wrB); default: return int'(wrC);
    endcase
  endfunction

  function automatic int getWc(int n);
    case (n)
      0: return int'(wcA); 1: return int'(wcB); default: return int'(wcC);
    endcase
  endfunction

  task automatic modelReset();
    for (int n = 0; n < 3; n++) begin
      mCnt[n] = 0;
      for (int i = 0; i < 8; i++) begin
        mDat[n][i] = 0; mWsh[n][i] = 0; mWact[n][i] = 0;
        mMacc[n][i] = 0; mAct[n][i] = 0; mSat[n][i] = 0;
      end
    end
  endtask

  // Advance every instance by one clock edge using the current stimulus.
  task automatic modelStep();
    int row, dw, sw, lo, hi, s, inD;
    bit inA, ovf, acc;
    for (int n = 0; n < 3; n++) begin
      row = cRow(n); dw = cDw(n); sw = cSw(n);
      lo = -(1 << (sw - 1));
      hi = (1 << (sw - 1)) - 1;
      for (int i = row - 1; i >= 0; i--) begin
        if (i == 0) begin
          inA = sAct; inD = wrapTo(sDat, dw);
        end else begin
          inA = mAct[n][i-1]; inD = mDat[n][i-1];
        end
        if (inA) begin
          s = inD * mWact[n][i] + wrapTo(sSum[i], sw);
          ovf = (s < lo) || (s > hi);
          if (ovf && cSat(n)) mMacc[n][i] = (s < lo) ? lo : hi;
          else                mMacc[n][i] = wrapTo(s, sw);
          mSat[n][i] = ovf;
        end
        mAct[n][i] = inA;
        mDat[n][i] = inD;
      end
      acc = sWswap && (mCnt[n] == row);
      if (acc) for (int i = 0; i < row; i++) mWact[n][i] = mWsh[n][i];
      if (sWload) begin
        for (int i = row - 1; i > 0; i--) mWsh[n][i] = mWsh[n][i-1];
        mWsh[n][0] = wrapTo(sWdat, dw);
      end
      if (acc)                          mCnt[n] = sWload ? 1 : 0;
      else if (sWload && mCnt[n] < row) mCnt[n] = mCnt[n] + 1;
    end
  endtask

  task automatic checkOutput(string name, int got, int exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic checkAll();
    int ea, es;
    for (int n = 0; n < 3; n++) begin
      ea = 0; es = 0;
      for (int i = 0; i < cRow(n); i++) begin
        checkOutput($sformatf("inst%0d maccout[%0d]", n, i), getMacc(n, i), mMacc[n][i]);
        if (mAct[n][i]) ea = ea | (1 << i);
        if (mSat[n][i]) es = es | (1 << i);
      end
      checkOutput($sformatf("inst%0d activeout", n), getAct(n), ea);
      checkOutput($sformatf("inst%0d satout", n), getSat(n), es);
      checkOutput($sformatf("inst%0d dataout", n), getData(n), mDat[n][cRow(n)-1]);
      checkOutput($sformatf("inst%0d wready", n), getWr(n), int'(mCnt[n] == cRow(n)));
      checkOutput($sformatf("inst%0d wcount", n), getWc(n), mCnt[n]);
    end
  endtask

  task automatic applyStimulus();
    active  = sAct;
    wload   = sWload;
    wswap   = sWswap;
    datainA = sDat[7:0];
    datainC = sDat[3:0];
    wdataA  = sWdat[7:0];
    wdataC  = sWdat[3:0];
    for (int i = 0; i < 4; i++) suminA[i*16 +: 16] = sSum[i][15:0];
    for (int i = 0; i < 8; i++) suminC[i*12 +: 12] = sSum[i][11:0];
  endtask

  task automatic idleStim();
    sAct = 0; sDat = 0; sWload = 0; sWdat = 0; sWswap = 0;
    for (int i = 0; i < 8; i++) sSum[i] = 0;
  endtask

  task automatic tick();
    applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic loadAndSwap(int w);
    idleStim();
    sWload = 1; sWdat = w;
    repeat (4) tick();
    sWload = 0; sWswap = 1;
    tick();
    sWswap = 0;
  endtask

  task automatic drain();
    idleStim();
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idleStim();
    applyStimulus();
    modelReset();
    #12;
    checkAll();
    checkOutput("reset wcount", int'(wcA), 0);
    rst_n = 1'b1;

    // basic load 4,3,2,1 then one activation of 5 with sumin 10
    sWload = 1;
    for (int v = 4; v >= 1; v--) begin
      sWdat = v;
      tick();
    end
    checkOutput("t1 wready", int'(wrA), 1);
    checkOutput("t1 wcount full", int'(wcA), 4);
    sWload = 0; sWswap = 1;
    tick();
    checkOutput("t1 wcount after swap", int'(wcA), 0);
    sWswap = 0; sAct = 1; sDat = 5;
    for (int i = 0; i < 8; i++) sSum[i] = 10;
    tick();
    checkOutput("t1 macc0", getMacc(0, 0), 15);
    checkOutput("t1 active0", int'(actA), 1);
    sAct = 0; sDat = 0;
    tick();
    checkOutput("t1 macc1", getMacc(0, 1), 20);
    checkOutput("t1 active1", int'(actA), 2);
    tick();
    checkOutput("t1 macc2", getMacc(0, 2), 25);
    tick();
    checkOutput("t1 macc3", getMacc(0, 3), 30);
    checkOutput("t1 dataout", getData(0), 5);
    drain();

    // positive overflow
    loadAndSwap(127);
    sAct = 1; sDat = 127;
    for (int i = 0; i < 8; i++) sSum[i] = 32512;
    tick();
    checkOutput("t2 wrap macc", getMacc(0, 0), -16895);
    checkOutput("t2 wrap sat", int'(satA[0]), 1);
    checkOutput("t2 sat macc", getMacc(1, 0), 32767);
    checkOutput("t2 sat flag", int'(satB[0]), 1);
    sDat = 1;
    for (int i = 0; i < 8; i++) sSum[i] = 0;
    tick();
    checkOutput("t2 no-ovf macc", getMacc(0, 0), 127);
    checkOutput("t2 no-ovf sat", int'(satA[0]), 0);
    drain();

    // signed extremes
    loadAndSwap(-128);
    sAct = 1; sDat = -128;
    tick();
    checkOutput("t3 minmin", getMacc(0, 0), 16384);
    checkOutput("t3 minmin sat", int'(satA[0]), 0);
    sDat = 127;
    for (int i = 0; i < 8; i++) sSum[i] = -32768;
    tick();
    checkOutput("t3 sat clamp", getMacc(1, 0), -32768);
    checkOutput("t3 sat flag", int'(satB[0]), 1);
    checkOutput("t3 wrap", getMacc(0, 0), 16512);
    drain();

    // handshake edge cases
    sWload = 1; sWdat = 9; tick();
    sWdat = 8; tick();
    checkOutput("t4 two loads", int'(wcA), 2);
    sWload = 0; sWswap = 1; tick();
    checkOutput("t4 ignored swap", int'(wcA), 2);
    sWswap = 0; sWload = 1;
    for (int v = 7; v >= 4; v--) begin
      sWdat = v;
      tick();
    end
    checkOutput("t4 saturated count", int'(wcA), 4);
    sWdat = 3; sWswap = 1; tick();
    checkOutput("t4 load+swap count", int'(wcA), 1);
    idleStim(); sAct = 1; sDat = 1; tick();
    checkOutput("t4 pre-shift weight0", getMacc(0, 0), 4);
    sAct = 0; sDat = 0;
    repeat (3) tick();
    checkOutput("t4 pre-shift weight3", getMacc(0, 3), 7);
    drain();

    // back-to-back stream with a swap midway
    sWload = 1;
    for (int i = 0; i < 4; i++) begin
      sWdat = $urandom;
      tick();
    end
    sWload = 0;
    for (int d = 1; d <= 8; d++) begin
      sAct = 1; sDat = d; sWswap = (d == 4);
      sWload = (d < 4); sWdat = d + 20;
      for (int i = 0; i < 8; i++) sSum[i] = $urandom_range(0, 200);
      tick();
      if (d == 5) checkOutput("t6 no gaps", int'(actA), 15);
    end
    drain();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      sAct   = ($urandom_range(0, 3) != 0);
      sDat   = $urandom;
      sWload = ($urandom_range(0, 2) == 0);
      sWdat  = $urandom;
      sWswap = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 8; i++)
        sSum[i] = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 300) - 150;
      tick();
    end

    // asynchronous reset mid-stream with three fresh weights
    drain();
    loadAndSwap(5);
    sWload = 1;
    for (int i = 0; i < 3; i++) begin
      sWdat = i + 2;
      tick();
    end
    checkOutput("t5 count before reset", int'(wcA), 3);
    sWload = 0; sAct = 1; sDat = 3;
    for (int i = 0; i < 8; i++) sSum[i] = 50;
    tick();
    tick();
    applyStimulus();
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("t5 macc cleared", int'(maccA != 0), 0);
    checkOutput("t5 wready cleared", int'(wrA), 0);
    #2;
    rst_n = 1'b1;
    idleStim();
    sAct = 1; sDat = 5;
    for (int i = 0; i < 8; i++) sSum[i] = 100 + i;
    tick();
    checkOutput("t5 passthrough", getMacc(0, 0), 100);
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
